// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider.
// Radix-2 restoring division, one quotient bit per cycle, then a single
// rounding cycle. Subnormal inputs are flushed to zero; results never
// produce subnormals (underflow goes to signed zero).
// Optional macro FP_DIV_EARLY_EXIT_EN: special-case operands (NaN, inf,
// zero) leave after classification instead of running the full iteration.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        zer,
    output logic        inf,
    output logic        nan,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Flag vector order: {ovrf, udrf, zer, inf, nan, dz}
    localparam logic [5:0] F_OVRF = 6'b100000;
    localparam logic [5:0] F_UDRF = 6'b010000;
    localparam logic [5:0] F_ZER  = 6'b001000;
    localparam logic [5:0] F_INF  = 6'b000100;
    localparam logic [5:0] F_NAN  = 6'b000010;
    localparam logic [5:0] F_DZ   = 6'b000001;

    localparam logic [4:0] LAST_ITER = 5'd25;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        x_q, x_d;
    logic [31:0]        y_q, y_d;
    logic [2:0]         rm_q, rm_d;
    logic [25:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        res_q, res_d;
    logic [5:0]         flg_q, flg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        z_q, z_d;
    logic [5:0]         flo_q, flo_d;

    // Operand preparation from the live inputs, used only on the accept edge
    logic [23:0]        mx_in, my_in;
    logic               lt_in;
    logic [25:0]        rem_init;
    logic signed [9:0]  exp_init;

    // Alignment: a dividend significand below the divisor's is doubled so the
    // first quotient bit is always 1; the exponent absorbs the shift.
    always_comb begin
        mx_in    = {1'b1, fp_X[22:0]};
        my_in    = {1'b1, fp_Y[22:0]};
        lt_in    = (mx_in < my_in);
        rem_init = lt_in ? {1'b0, mx_in, 1'b0} : {2'b00, mx_in};
        exp_init = $signed({2'b00, fp_X[30:23]}) - $signed({2'b00, fp_Y[30:23]})
                 + 10'sd127 - $signed({9'd0, lt_in});
    end

    // Classification of the latched operands
    logic        sign_z;
    logic        x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
    logic        is_special;
    logic [31:0] spec_z;
    logic [5:0]  spec_f;

    // Special-case resolution; subnormals (exponent 0) count as zero
    always_comb begin
        sign_z = x_q[31] ^ y_q[31];
        x_zero = (x_q[30:23] == 8'h00);
        x_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == '0);
        x_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != '0);
        y_zero = (y_q[30:23] == 8'h00);
        y_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == '0);
        y_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != '0);

        is_special = 1'b1;
        spec_z     = '0;
        spec_f     = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_z = 32'h7FC0_0000;
            spec_f = F_NAN;
        end else if (x_inf) begin
            spec_z = {sign_z, 8'hFF, 23'd0};
            spec_f = F_INF;
        end else if (y_zero) begin
            spec_z = {sign_z, 8'hFF, 23'd0};
            spec_f = F_INF | F_DZ;
        end else if (x_zero || y_inf) begin
            spec_z = {sign_z, 31'd0};
            spec_f = F_ZER;
        end else begin
            is_special = 1'b0;
        end
    end

    // One restoring-division step
    logic [23:0] my;
    logic        q_bit;
    logic [25:0] rem_sub;

    // Trial subtract of the divisor; remainder shifts left for the next bit
    always_comb begin
        my      = {1'b1, y_q[22:0]};
        q_bit   = (rem_q >= {2'b00, my});
        rem_sub = q_bit ? (rem_q - {2'b00, my}) : rem_q;
    end

    // Rounding of the finished quotient
    logic               guard, rbit, sticky, inexact, rnd_inc, carry;
    logic [22:0]        frac_r;
    logic signed [9:0]  exp_r;
    logic [31:0]        norm_z;
    logic [5:0]         norm_f;
    logic [31:0]        final_z;
    logic [5:0]         final_f;

    // quo_q keeps the 25 bits after the leading 1 (which has shifted out):
    // fraction[22:0], guard, round. Sticky is the final remainder.
    always_comb begin
        guard   = quo_q[1];
        rbit    = quo_q[0];
        sticky  = |rem_q;
        inexact = guard | rbit | sticky;
        case (rm_q)
            3'b001:  rnd_inc = 1'b0;
            3'b010:  rnd_inc = sign_z & inexact;
            3'b011:  rnd_inc = ~sign_z & inexact;
            3'b100:  rnd_inc = guard;
            default: rnd_inc = guard & (rbit | sticky | quo_q[2]);
        endcase
        carry  = rnd_inc & (&quo_q[24:2]);
        frac_r = quo_q[24:2] + {22'd0, rnd_inc};
        exp_r  = exp_q + $signed({9'd0, carry});

        if (exp_r >= 10'sd255) begin
            norm_z = {sign_z, 8'hFF, 23'd0};
            norm_f = F_OVRF | F_INF;
        end else if (exp_r <= 10'sd0) begin
            norm_z = {sign_z, 31'd0};
            norm_f = F_UDRF | F_ZER;
        end else begin
            norm_z = {sign_z, exp_r[7:0], frac_r};
            norm_f = '0;
        end

        final_z = is_special ? spec_z : norm_z;
        final_f = is_special ? spec_f : norm_f;
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        rm_d    = rm_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        res_d   = res_q;
        flg_d   = flg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        flo_d   = flo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    cnt_d   = '0;
                    x_d     = fp_X;
                    y_d     = fp_Y;
                    rm_d    = r_mode;
                    rem_d   = rem_init;
                    quo_d   = '0;
                    exp_d   = exp_init;
                    busy_d  = 1'b1;
                end
            end
            DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[23:0], q_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ROUND;
                    cnt_d   = '0;
                end
`ifdef FP_DIV_EARLY_EXIT_EN
                // Classification needs the latched operands, so special
                // cases are recognised in the first cycle after accept.
                if (cnt_q == '0 && is_special) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = spec_z;
                    flg_d   = spec_f;
                end
`endif
            end
            ROUND: begin
                res_d   = final_z;
                flg_d   = final_f;
                state_d = DONE;
            end
            DONE: begin
                // Result and done are registered on leaving DONE
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                z_d     = res_q;
                flo_d   = flg_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rm_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            flo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rm_q    <= rm_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            flo_q   <= flo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign fp_Z = z_q;
    assign {ovrf, udrf, zer, inf, nan, dz} = flo_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed and random checks of fp_div_seq against an
// integer-arithmetic model of single-precision division and rounding.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] fp_X, fp_Y;
    logic [2:0]  r_mode;
    logic        busy, done;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, zer, inf, nan, dz;
    logic [5:0]  flags;

    int total = 0;
    int bad   = 0;

    assign flags = {ovrf, udrf, zer, inf, nan, dz};

    fp_div_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .fp_X   (fp_X),
        .fp_Y   (fp_Y),
        .r_mode (r_mode),
        .busy   (busy),
        .done   (done),
        .fp_Z   (fp_Z),
        .ovrf   (ovrf),
        .udrf   (udrf),
        .zer    (zer),
        .inf    (inf),
        .nan    (nan),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: quotient from exact integer division, rounded by mode rules
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    input logic [2:0] rm, output logic [31:0] z,
                                    output logic [5:0] f, output bit sp);
        int     ex, ey, e;
        longint mx, my, num, q, sig;
        bit     s, g, rb, st, inx, up, xz, xi, xn, yz, yi, yn;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);  xi = (ex == 255) && (x[22:0] == 0); xn = (ex == 255) && (x[22:0] != 0);
        yz = (ey == 0);  yi = (ey == 255) && (y[22:0] == 0); yn = (ey == 255) && (y[22:0] != 0);
        sp = 1'b1;
        z  = '0;
        f  = '0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            z = 32'h7FC0_0000; f = 6'b000010;
        end else if (xi) begin
            z = {s, 8'hFF, 23'd0}; f = 6'b000100;
        end else if (yz) begin
            z = {s, 8'hFF, 23'd0}; f = 6'b000101;
        end else if (xz || yi) begin
            z = {s, 31'd0}; f = 6'b001000;
        end else begin
            sp  = 1'b0;
            mx  = longint'({1'b1, x[22:0]});
            my  = longint'({1'b1, y[22:0]});
            e   = ex - ey + 127;
            if (mx < my) begin
                num = mx << 26;
                e   = e - 1;
            end else begin
                num = mx << 25;
            end
            q   = num / my;
            st  = (num % my) != 0;
            sig = q >> 2;
            g   = q[1];
            rb  = q[0];
            inx = g | rb | st;
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = s & inx;
                3'd3:    up = !s & inx;
                3'd4:    up = g;
                default: up = g & (rb | st | sig[0]);
            endcase
            sig = sig + longint'(up);
            if (sig == (64'sd1 <<< 24)) begin
                sig = 64'sd1 <<< 23;
                e   = e + 1;
            end
            if (e >= 255) begin
                z = {s, 8'hFF, 23'd0}; f = 6'b100100;
            end else if (e <= 0) begin
                z = {s, 31'd0}; f = 6'b011000;
            end else begin
                z = {s, 8'(e), 23'(sig)};
            end
        end
    endfunction

    // mode 0: plain op; 1: extra start pulse while busy; 2: reset at accept+10
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm, input int mode);
        logic [31:0] ez, lat, exp_lat;
        logic [5:0]  ef;
        bit          sp;
        int          seen;
        ref_div(x, y, rm, ez, ef, sp);
        exp_lat = 32'd28;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (sp) exp_lat = 32'd2;
`endif
        @(negedge clk);
        fp_X = x; fp_Y = y; r_mode = rm; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        fp_X   = $urandom;
        fp_Y   = $urandom;
        r_mode = 3'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 32'hFFFF_FFFF;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (mode == 1 && k == 4) begin
                fp_X  = 32'h4120_0000;
                fp_Y  = 32'h3F80_0000;
                start = 1'b1;
            end
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 9) rst = 1'b1;
            if (mode == 2 && k == 10) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_fp_Z", fp_Z, 32'd0);
                check("abort_flags", 32'(flags), 32'd0);
                rst  = 1'b0;
                seen = 0;
                repeat (35) begin
                    @(posedge clk);
                    #1;
                    if (done) seen++;
                end
                check("abort_no_done", 32'(seen), 32'd0);
                return;
            end
            if (done) begin
                lat = 32'(k);
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("fp_Z", fp_Z, ez);
        check("flags", 32'(flags), 32'(ef));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("fp_Z_held", fp_Z, ez);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:0]  = '0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'($urandom_range(230, 254));
            5:       v[30:23] = 8'($urandom_range(1, 25));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; fp_X = '0; fp_Y = '0; r_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_fp_Z", fp_Z, 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;

        // First op starts in the first cycle after reset release
        do_op(32'h40C0_0000, 32'h4000_0000, 3'd0, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd0, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd1, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd3, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd2, 0);
        do_op(32'hBF80_0000, 32'h4040_0000, 3'd2, 0);
        do_op(32'hBF80_0000, 32'h4040_0000, 3'd4, 0);
        do_op(32'h3F80_0000, 32'h0000_0000, 3'd0, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 3'd0, 0);
        do_op(32'h7F80_0000, 32'h7F80_0000, 3'd0, 0);
        do_op(32'hFF80_0000, 32'h4000_0000, 3'd0, 0);
        do_op(32'h4000_0000, 32'hFF80_0000, 3'd0, 0);
        do_op(32'h0000_1234, 32'h4000_0000, 3'd0, 0);
        do_op(32'h7F00_0000, 32'h0080_0000, 3'd1, 0);
        do_op(32'h0080_0000, 32'h7F00_0000, 3'd3, 0);
        do_op(32'h3FFF_FFFF, 32'h3F80_0001, 3'd7, 0);

        do_op(32'h40C0_0000, 32'h4000_0000, 3'd0, 1);
        do_op(32'h40C0_0000, 32'h4000_0000, 3'd0, 2);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(rand_fp(), rand_fp(), 3'($urandom_range(0, 7)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have ports, clock and reset first, each listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- fp_X  in  32  IEEE-754 single-precision dividend.
- fp_Y  in  32  IEEE-754 single-precision divisor.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse; result valid.
- fp_Z  out  32  quotient; held until the next accept.
- ovrf, udrf, zer, inf, nan, dz  out  1 each  exception flags, held with fp_Z.

REQ-002 SHALL have a single clock and no parameters.

Function
REQ-003 SHALL latch fp_X, fp_Y and r_mode on the accept edge (start=1 in IDLE); later input changes SHALL NOT affect the operation in flight.
REQ-004 SHALL ignore start while busy=1.
REQ-005 SHALL use states IDLE, DIV, ROUND, DONE.
REQ-006 SHALL follow these state transitions:
- IDLE to DIV on accept.
- DIV for exactly 26 cycles, then ROUND.
- ROUND for 1 cycle, then DONE.
- DONE for 1 cycle with done=1, then IDLE.
REQ-007 SHALL assert done exactly 28 cycles after the accept edge on the normal path.
REQ-008 SHALL flush subnormal inputs (exponent field 0) to signed zero before classification.
REQ-009 SHALL compute sign_Z = fp_X[31] XOR fp_Y[31] for every result except NaN.
REQ-010 SHALL form the significands mX = {1,frc_X} and mY = {1,frc_Y}; if mX < mY, the dividend SHALL be mX<<1 and the exponent reduced by 1.
REQ-011 SHALL compute the biased exponent as eX - eY + 127 (minus 1 per REQ-010) in 10-bit signed arithmetic.
REQ-012 SHALL run a radix-2 restoring division producing 1 quotient bit per DIV cycle: 24 significand bits, guard, round; sticky SHALL be the OR of the final remainder.
REQ-013 SHALL round in ROUND per r_mode:
- RNE: increment if guard AND (round OR sticky OR lsb).
- RTZ: never increment.
- RDN: increment if sign_Z=1 AND any of guard, round or sticky is set.
- RUP: increment if sign_Z=0 AND any of guard, round or sticky is set.
- RMM: increment if guard.
REQ-014 SHALL, on a rounding carry out of bit 23, set the fraction to 0 and increment the exponent.
REQ-015 SHALL, when the final exponent is >= 255, set fp_Z = {sign_Z, 8'hFF, 23'b0}, ovrf=1, inf=1, for every r_mode.
REQ-016 SHALL, when the final exponent is <= 0, set fp_Z = {sign_Z, 31'b0}, udrf=1, zer=1.
REQ-017 SHALL resolve special cases as follows:
- X NaN, Y NaN, 0/0 or inf/inf: fp_Z = 32'h7FC00000, nan=1.
- finite nonzero / 0: fp_Z = ±inf, inf=1, dz=1.
- inf / finite: fp_Z = ±inf, inf=1.
- 0 / nonzero or finite / inf: fp_Z = ±0, zer=1.
REQ-018 SHALL clear all flags not set by the current operation when its result is written.
REQ-019 SHALL update fp_Z and the flags only on the cycle done rises.

Reset
REQ-020 SHALL, while rst=1 at a clock edge, force the following, including mid-operation (the operation is aborted and no done is issued):
- state = IDLE.
- busy = 0, done = 0.
- fp_Z = 0.
- all flags = 0.
- iteration counter = 0.
REQ-021 SHALL allow start on the first cycle after rst deasserts to be accepted.

Configuration
REQ-022 SHALL support macro FP_DIV_EARLY_EXIT_EN:
- Defined: REQ-017 cases skip DIV and ROUND, going IDLE to DONE with done 2 cycles after accept.
- Undefined: all operations take the 28-cycle path with identical results.

Verification
REQ-023 SHALL cover these directed scenarios:
- 40C00000 / 40000000, RNE -> fp_Z=40400000, all flags 0, done at accept+28.
- 3F800000 / 40400000 -> RNE 3EAAAAAB; RTZ 3EAAAAAA; RUP 3EAAAAAB; RDN 3EAAAAAA.
- 3F800000 / 00000000 -> fp_Z=7F800000, inf=1, dz=1; 00000000 / 00000000 -> 7FC00000, nan=1; done at accept+2 only with FP_DIV_EARLY_EXIT_EN.
- 7F000000 / 00800000 -> fp_Z=7F800000, ovrf=1, inf=1; 00800000 / 7F000000 -> fp_Z=00000000, udrf=1, zer=1.
- start pulsed during busy with different operands -> ignored, original result delivered.
- rst=1 at accept+10 -> busy=0, done never pulses, fp_Z=0; new start next cycle completes correctly.
